// File: rtl/count_display_pkg.sv
// Shared constants for the count display: active-low {G..A} digit patterns and wrap-blink states.
// Pure declarations, no logic; imported by count_display_mux and seg7_decode.
// No handshake: nothing here carries state.
package count_display_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FLASH_OFF = 2'd1,
        FLASH_ON  = 2'd2
    } flash_state_t;

    // The counter rolling over in either direction between its two extremes.
    function automatic logic is_wrap(input logic [3:0] prev, input logic [3:0] cur);
        return ((prev == 4'hF) && (cur == 4'h0)) || ((prev == 4'h0) && (cur == 4'hF));
    endfunction

endpackage

// File: rtl/count_display_mux_seg7_decode.sv
// Decimal digit to active-low seven-segment pattern; 10-15 decode to blank.
// Latency: combinational.
// Backpressure: none.
module seg7_decode
    import count_display_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] segments
);

    always_comb begin
        segments = SEG_BLANK;
        case (digit)
            4'd0: segments = SEG_0;
            4'd1: segments = SEG_1;
            4'd2: segments = SEG_2;
            4'd3: segments = SEG_3;
            4'd4: segments = SEG_4;
            4'd5: segments = SEG_5;
            4'd6: segments = SEG_6;
            4'd7: segments = SEG_7;
            4'd8: segments = SEG_8;
            4'd9: segments = SEG_9;
            default: segments = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/count_display_mux.sv
// Two-digit multiplexed seven-segment driver showing the 4-bit press count as 0-15; DISPLAY_WRAP_FLASH_EN adds a wrap blink.
// Latency: 2 cycles from i_Count to o_Segments (input register + output register).
// Backpressure: none; the count is sampled every cycle.
module count_display_mux
    import count_display_pkg::*;
#(
    parameter int REFRESH_DIV = 2500,
    parameter int FLASH_HALF  = 6250000,
    parameter int FLASH_COUNT = 3
) (
    input  logic       CLK,
    input  logic       i_Rst_L,
    input  logic [3:0] i_Count,
    output logic [6:0] o_Segments,
    output logic [1:0] o_Digit_En,
    output logic       o_Flashing
);

    if ((REFRESH_DIV < 2) || (FLASH_HALF < 1) || (FLASH_COUNT < 1)) begin : g_bad_params
        $error("count_display_mux: parameter out of range");
    end

    localparam int                REF_W    = $clog2(REFRESH_DIV);
    localparam logic [REF_W-1:0]  REF_LAST = REF_W'(REFRESH_DIV - 1);

    logic [3:0]       r_Count;
    logic [REF_W-1:0] r_Refresh;
    logic             r_Digit_Sel;
    logic             w_Tens;
    logic [3:0]       w_Ones;
    logic [6:0]       w_Ones_Seg;
    logic [6:0]       w_Tens_Raw;
    logic [6:0]       w_Tens_Seg;
    logic             w_Blank;

    always_ff @(posedge CLK or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Count <= 4'd0;
        end else begin
            r_Count <= i_Count;
        end
    end

    assign w_Tens = (r_Count >= 4'd10);
    assign w_Ones = w_Tens ? (r_Count - 4'd10) : r_Count;

    seg7_decode u_ones_dec (
        .digit    (w_Ones),
        .segments (w_Ones_Seg)
    );

    seg7_decode u_tens_dec (
        .digit    ({3'b000, w_Tens}),
        .segments (w_Tens_Raw)
    );

    // Leading zero on the tens digit is never lit.
    assign w_Tens_Seg = w_Tens ? w_Tens_Raw : SEG_BLANK;

    // Free-running scan; count changes never disturb the digit timing.
    always_ff @(posedge CLK or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Refresh   <= '0;
            r_Digit_Sel <= 1'b0;
        end else if (r_Refresh == REF_LAST) begin
            r_Refresh   <= '0;
            r_Digit_Sel <= ~r_Digit_Sel;
        end else begin
            r_Refresh   <= r_Refresh + 1'b1;
        end
    end

`ifdef DISPLAY_WRAP_FLASH_EN
    localparam int                 HALF_W     = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam int                 BLINK_W    = $clog2(FLASH_COUNT + 1);
    localparam logic [HALF_W-1:0]  HALF_LAST  = HALF_W'(FLASH_HALF - 1);
    localparam logic [BLINK_W-1:0] BLINK_FULL = BLINK_W'(FLASH_COUNT);

    logic [3:0]         r_Count_Prev;
    flash_state_t       r_State;
    logic [HALF_W-1:0]  r_Half;
    logic [BLINK_W-1:0] r_Blinks;
    logic               w_Wrap;

    always_ff @(posedge CLK or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_Count_Prev <= 4'd0;
        end else begin
            r_Count_Prev <= r_Count;
        end
    end

    assign w_Wrap = is_wrap(r_Count_Prev, r_Count);

    // A wrap always restarts the sequence from a full off phase, whatever state we are in.
    always_ff @(posedge CLK or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            r_State    <= IDLE;
            r_Half     <= '0;
            r_Blinks   <= '0;
            o_Flashing <= 1'b0;
        end else begin
            o_Flashing <= (r_State != IDLE);
            if (w_Wrap) begin
                r_State  <= FLASH_OFF;
                r_Half   <= HALF_LAST;
                r_Blinks <= BLINK_FULL;
            end else begin
                case (r_State)
                    FLASH_OFF: begin
                        if (r_Half == '0) begin
                            r_State <= FLASH_ON;
                            r_Half  <= HALF_LAST;
                        end else begin
                            r_Half  <= r_Half - 1'b1;
                        end
                    end
                    FLASH_ON: begin
                        if (r_Half == '0) begin
                            r_Blinks <= r_Blinks - 1'b1;
                            if (r_Blinks == BLINK_W'(1)) begin
                                r_State <= IDLE;
                            end else begin
                                r_State <= FLASH_OFF;
                                r_Half  <= HALF_LAST;
                            end
                        end else begin
                            r_Half <= r_Half - 1'b1;
                        end
                    end
                    default: r_State <= IDLE;
                endcase
            end
        end
    end

    assign w_Blank = (r_State == FLASH_OFF);
`else
    assign w_Blank    = 1'b0;
    assign o_Flashing = 1'b0;
`endif

    // Enable and pattern come from the same select register so they always switch together.
    always_ff @(posedge CLK or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            o_Segments <= SEG_BLANK;
            o_Digit_En <= 2'b11;
        end else begin
            o_Digit_En <= r_Digit_Sel ? 2'b01 : 2'b10;
            if (w_Blank) begin
                o_Segments <= SEG_BLANK;
            end else begin
                o_Segments <= r_Digit_Sel ? w_Tens_Seg : w_Ones_Seg;
            end
        end
    end

endmodule

// File: tb/tb_count_display_mux.sv
// Directed bench for count_display_mux: reset, digit scan, blanking and (with DISPLAY_WRAP_FLASH_EN) the wrap blink.
module tb_count_display_mux;

    localparam int RDIV  = 4;
    localparam int FHALF = 8;
    localparam int FCNT  = 2;
`ifdef DISPLAY_WRAP_FLASH_EN
    localparam bit FLASH_BUILD = 1'b1;
`else
    localparam bit FLASH_BUILD = 1'b0;
`endif

    logic       CLK = 1'b0;
    logic       i_Rst_L;
    logic [3:0] i_Count;
    logic [6:0] o_Segments;
    logic [1:0] o_Digit_En;
    logic       o_Flashing;

    always #5 CLK = ~CLK;

    count_display_mux #(
        .REFRESH_DIV (RDIV),
        .FLASH_HALF  (FHALF),
        .FLASH_COUNT (FCNT)
    ) dut (
        .CLK        (CLK),
        .i_Rst_L    (i_Rst_L),
        .i_Count    (i_Count),
        .o_Segments (o_Segments),
        .o_Digit_En (o_Digit_En),
        .o_Flashing (o_Flashing)
    );

    typedef struct {
        logic [3:0] cnt;
        logic [6:0] ones;
        logic [6:0] tens;
    } vec_t;

    logic [6:0] digit_lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                   7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    int n_cmp = 0;
    int n_bad = 0;
    int k     = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at k=%0d: got %0h, expected %0h", name, k, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
        k++;
    endtask

    function automatic logic [1:0] exp_en(input int kk);
        return ((((kk - 1) / RDIV) % 2) == 1) ? 2'b01 : 2'b10;
    endfunction

    function automatic logic [6:0] exp_seg(input int val, input int kk);
        if (exp_en(kk) == 2'b01) return (val >= 10) ? digit_lut[1] : 7'h7F;
        return digit_lut[(val >= 10) ? val - 10 : val];
    endfunction

    function automatic bit is_wrap_tb(input int a, input int b);
        return ((a == 15) && (b == 0)) || ((a == 0) && (b == 15));
    endfunction

    // d = output edges since the FSM entered the off phase
    function automatic void blink_exp(input int d, output bit blank, output bit flash);
        flash = (d >= 1) && (d <= 2 * FCNT * FHALF);
        blank = flash && ((((d - 1) / FHALF) % 2) == 0);
    endfunction

    task automatic check_out(input string tag, input int val, input bit blank, input bit flash);
        check({tag, " seg"}, int'(o_Segments), blank ? 32'h7F : int'(exp_seg(val, k)));
        check({tag, " en"}, int'(o_Digit_En), int'(exp_en(k)));
        check({tag, " flash"}, int'(o_Flashing), int'(flash));
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " seg"}, int'(o_Segments), 32'h7F);
        check({tag, " en"}, int'(o_Digit_En), 32'h3);
        check({tag, " flash"}, int'(o_Flashing), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [6];
        int   disp, pend_v, pend_k, e_cur, e_pend, cur_in, nv;
        bit   blank, flash;

        vecs[0] = '{4'd13, 7'h30, 7'h79};
        vecs[1] = '{4'd5,  7'h12, 7'h7F};
        vecs[2] = '{4'd0,  7'h40, 7'h7F};
        vecs[3] = '{4'd9,  7'h10, 7'h7F};
        vecs[4] = '{4'd10, 7'h40, 7'h79};
        vecs[5] = '{4'd15, 7'h12, 7'h79};

        // Reset held with a nonzero count applied.
        i_Rst_L = 1'b0;
        i_Count = 4'd7;
        repeat (3) @(posedge CLK);
        #1;
        check_reset_vals("reset");

        @(negedge CLK);
        i_Rst_L = 1'b1;
        k = 0;
        step();
        check("release en", int'(o_Digit_En), 32'h2);
        check("release seg", int'(o_Segments), 32'h40);
        step();
        check("count 7 seg", int'(o_Segments), 32'h78);

        // Steady counts: ones and tens phases alternate every RDIV cycles.
        for (int i = 0; i < 6; i++) begin
            i_Count = vecs[i].cnt;
            step();
            for (int c = 0; c < 2 * RDIV; c++) begin
                step();
                check($sformatf("vec%0d seg", i), int'(o_Segments),
                      (exp_en(k) == 2'b01) ? int'(vecs[i].tens) : int'(vecs[i].ones));
                check($sformatf("vec%0d en", i), int'(o_Digit_En), int'(exp_en(k)));
            end
        end

        // Wrap blink: full sequence, then restarts mid-blink and a plain count change.
        disp   = 15;
        pend_v = 15;
        pend_k = -1;
        e_cur  = -1000;
        e_pend = -1;
        cur_in = 15;
        for (int it = 0; it < 110; it++) begin
            case (it)
                0:       nv = 0;
                40:      nv = 15;
                50:      nv = 0;
                56:      nv = 15;
                70:      nv = 14;
                default: nv = -1;
            endcase
            if (nv >= 0) begin
                if (FLASH_BUILD && is_wrap_tb(cur_in, nv)) e_pend = k + 2;
                pend_v  = nv;
                pend_k  = k + 2;
                cur_in  = nv;
                i_Count = 4'(nv);
            end
            step();
            if (k == pend_k) disp = pend_v;
            blink_exp(k - e_cur, blank, flash);
            check_out($sformatf("blink it%0d", it), disp, blank, flash);
            if (k == e_pend) e_cur = e_pend;
        end

        // Asynchronous reset in the middle of an off phase.
        i_Count = 4'd15;
        repeat (3) step();
        i_Count = 4'd0;
        repeat (6) step();
        check_out("pre-reset", 0, FLASH_BUILD, FLASH_BUILD);
        #2;
        i_Rst_L = 1'b0;
        #1;
        check_reset_vals("async reset");
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        i_Rst_L = 1'b1;
        k = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            check_out("post-reset", 0, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
